// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, 16x oversampled with 3-sample majority vote
// Delivers bytes through a valid/ack holding register; flags framing errors and overruns.
module uart_rx #(
  parameter int FREQUENCY = 18_432_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       i_clock,
  input  logic       i_rst,
  input  logic       i_rx_serial,
  input  logic       i_rx_ack,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_rx_busy
);

  localparam int CLKS_PER_TICK = FREQUENCY / (16 * BAUD_RATE);
  localparam int TW = $clog2(CLKS_PER_TICK) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  logic            rx_meta, rx_s;
  logic [1:0]      sync_ok;
  logic            armed;
  logic [TW-1:0]   tick_cnt;
  logic [3:0]      sample_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift_reg;
  logic            vote7, vote8;
  logic            tick, mid_tick, end_tick, vote;
  logic            start_frame, byte_done;

  assign tick     = (tick_cnt == TICK_LAST);
  assign mid_tick = tick && (sample_cnt == 4'd9);
  assign end_tick = tick && (sample_cnt == 4'd15);
  assign vote     = (vote7 & vote8) | (vote7 & rx_s) | (vote8 & rx_s);
  assign o_rx_busy = (state != IDLE);

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    byte_done   = 1'b0;
    case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_next  = START;
          start_frame = 1'b1;
        end
      end
      START: begin
        if (mid_tick && vote) state_next = IDLE;
        else if (end_tick)    state_next = DATA;
      end
      DATA: begin
        if (end_tick && bit_idx == 3'd7) state_next = STOP;
      end
      STOP: begin
        // Leave mid-stop so a back-to-back start edge is not missed.
        if (mid_tick) begin
          state_next = IDLE;
          byte_done  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      state       <= IDLE;
      rx_meta     <= 1'b1;
      rx_s        <= 1'b1;
      sync_ok     <= 2'b00;
      armed       <= 1'b0;
      tick_cnt    <= '0;
      sample_cnt  <= 4'd0;
      bit_idx     <= 3'd0;
      shift_reg   <= 8'd0;
      vote7       <= 1'b0;
      vote8       <= 1'b0;
      o_rx_byte   <= 8'd0;
      o_rx_valid  <= 1'b0;
      o_frame_err <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      state   <= state_next;
      rx_meta <= i_rx_serial;
      rx_s    <= rx_meta;
      sync_ok <= {sync_ok[0], 1'b1};

      // Arm only on a genuine high seen after the preset sync values have flushed.
      if (state != IDLE || start_frame) armed <= 1'b0;
      else if (rx_s && sync_ok[1])      armed <= 1'b1;

      if (state == IDLE) begin
        tick_cnt   <= '0;
        sample_cnt <= 4'd0;
      end else if (tick) begin
        tick_cnt   <= '0;
        sample_cnt <= sample_cnt + 4'd1;
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end

      if (tick && sample_cnt == 4'd7) vote7 <= rx_s;
      if (tick && sample_cnt == 4'd8) vote8 <= rx_s;

      if (state == START && end_tick) bit_idx <= 3'd0;
      if (state == DATA && mid_tick)  shift_reg[bit_idx] <= vote;
      if (state == DATA && end_tick)  bit_idx <= bit_idx + 3'd1;

      o_frame_err <= byte_done && !vote;

      if (byte_done) begin
        o_rx_byte  <= shift_reg;
        o_rx_valid <= 1'b1;
      end else if (i_rx_ack) begin
        o_rx_valid <= 1'b0;
      end

      if (byte_done && o_rx_valid && !i_rx_ack) o_overrun <= 1'b1;
      else if (i_rx_ack && o_rx_valid)          o_overrun <= 1'b0;
    end
  end

endmodule
